// File: rtl/snake_pkg.sv
// Shared constants, direction encodings and segment pack/unpack helpers for the snake pipeline.
package snake_pkg;

   localparam int unsigned SEG_W     = 8;
   localparam int unsigned MAX_SEGS  = 225;
   localparam int unsigned GRID_BITS = 4;

   typedef enum logic [1:0] {
      DIR_UP    = 2'b00,
      DIR_RIGHT = 2'b01,
      DIR_DOWN  = 2'b10,
      DIR_LEFT  = 2'b11
   } dir_e;

   // One body segment as stored in the packed body vector.
   typedef struct packed {
      logic [GRID_BITS-1:0] y;
      logic [GRID_BITS-1:0] x;
   } seg_t;

   function automatic logic [SEG_W-1:0] seg_pack(input logic [GRID_BITS-1:0] x,
                                                 input logic [GRID_BITS-1:0] y);
      return {y, x};
   endfunction

   function automatic logic [GRID_BITS-1:0] seg_x(input logic [SEG_W-1:0] s);
      return s[GRID_BITS-1:0];
   endfunction

   function automatic logic [GRID_BITS-1:0] seg_y(input logic [SEG_W-1:0] s);
      return s[SEG_W-1:GRID_BITS];
   endfunction

endpackage

// File: rtl/snake_head_step.sv
// Combinational head stepper: wrapped next head for a direction, plus 180-degree reversal flag.
module snake_head_step
   import snake_pkg::*;
(
   input  logic [GRID_BITS-1:0] head_x_i,
   input  logic [GRID_BITS-1:0] head_y_i,
   input  logic [1:0]           dir_i,
   input  logic [1:0]           cur_dir_i,
   output logic [GRID_BITS-1:0] next_x_o,
   output logic [GRID_BITS-1:0] next_y_o,
   output logic                 is_reverse_o
);

   // Opposite directions differ only in the upper encoding bit.
   assign is_reverse_o = ((dir_i ^ cur_dir_i) == 2'b10);

   // Step one cell; 4-bit arithmetic gives the torus wrap on both axes.
   always_comb begin
      next_x_o = head_x_i;
      next_y_o = head_y_i;
      case (dir_i)
         DIR_UP:    next_y_o = head_y_i - GRID_BITS'(1);
         DIR_RIGHT: next_x_o = head_x_i + GRID_BITS'(1);
         DIR_DOWN:  next_y_o = head_y_i + GRID_BITS'(1);
         default:   next_x_o = head_x_i - GRID_BITS'(1);
      endcase
   end

endmodule

// File: rtl/snake_body_updater.sv
// Snake game-state stage: owns the packed body, advances it per tick, scans for self-collision.
module snake_body_updater #(
   parameter int unsigned MAX_SEGS = snake_pkg::MAX_SEGS,
   parameter int unsigned INIT_LEN = 3,
   parameter int unsigned INIT_X   = 8,
   parameter int unsigned INIT_Y   = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  tick,
   input  logic [1:0]            dir,
   input  logic                  grow,
   output logic [MAX_SEGS*8-1:0] snake_out,
   output logic [10:0]           index,
   output logic [3:0]            head_x,
   output logic [3:0]            head_y,
   output logic                  busy,
   output logic                  done,
   output logic                  collision
);
   import snake_pkg::*;

   localparam int unsigned BODY_W = MAX_SEGS * SEG_W;
   localparam int unsigned LEN_W  = $clog2(MAX_SEGS + 1);
   localparam int unsigned POS_W  = $clog2(BODY_W + 1);
   localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_SEGS);
   localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_MOVE,
      S_SCAN,
      S_DONE,
      S_DEAD
   } state_e;

   state_e            state_q;
   logic [BODY_W-1:0] body_q, body_d, init_body;
   logic [LEN_W-1:0]  len_q, len_d, scan_q;
   logic [10:0]       index_q;
   logic [1:0]        dir_q, step_dir;
   logic              grow_q, busy_q, done_q, coll_q;
   logic [3:0]        next_x, next_y;
   logic              is_reverse;
   logic [POS_W-1:0]  tail_pos, scan_pos;
   seg_t              head_seg, scan_seg;

   // Reset image of the body: a horizontal line trailing left of the initial head.
   for (genvar k = 0; k < int'(MAX_SEGS); k++) begin : g_init
      if (k < int'(INIT_LEN)) begin : g_on
         assign init_body[k*SEG_W +: SEG_W] = seg_pack(4'(INIT_X - k), 4'(INIT_Y));
      end else begin : g_off
         assign init_body[k*SEG_W +: SEG_W] = '0;
      end
   end

   // In MOVE the latched direction drives the stepper; otherwise the live request is checked for reversal.
   assign step_dir = (state_q == S_MOVE) ? dir_q : dir;

   snake_head_step u_step (
      .head_x_i     (seg_x(body_q[SEG_W-1:0])),
      .head_y_i     (seg_y(body_q[SEG_W-1:0])),
      .dir_i        (step_dir),
      .cur_dir_i    (dir_q),
      .next_x_o     (next_x),
      .next_y_o     (next_y),
      .is_reverse_o (is_reverse)
   );

   assign tail_pos = POS_W'(32'(len_q) * SEG_W);
   assign scan_pos = POS_W'(32'(scan_q) * SEG_W);
   assign head_seg = seg_t'(body_q[SEG_W-1:0]);
   assign scan_seg = seg_t'(body_q[scan_pos +: SEG_W]);

   // Shifted body and new length for the MOVE edge; old tail is cleared unless the snake grows.
   always_comb begin
      len_d  = len_q;
      body_d = {body_q[BODY_W-SEG_W-1:0], seg_pack(next_x, next_y)};
      if (grow_q && (len_q < MAX_LEN)) begin
         len_d = len_q + ONE;
      end else if (len_q < MAX_LEN) begin
         body_d[tail_pos +: SEG_W] = '0;
      end
   end

   // Move/scan sequencer with all outputs registered.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         body_q  <= init_body;
         len_q   <= LEN_W'(INIT_LEN);
         index_q <= 11'((INIT_LEN - 1) * SEG_W);
         dir_q   <= DIR_RIGHT;
         grow_q  <= 1'b0;
         scan_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         coll_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (tick && !coll_q) begin
                  grow_q  <= grow;
                  dir_q   <= is_reverse ? dir_q : dir;
                  busy_q  <= 1'b1;
                  state_q <= S_MOVE;
               end
            end
            S_MOVE: begin
               body_q  <= body_d;
               len_q   <= len_d;
               index_q <= 11'(32'(len_d - ONE) * SEG_W);
               scan_q  <= ONE;
               state_q <= S_SCAN;
            end
            S_SCAN: begin
               if (scan_seg == head_seg) begin
                  coll_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end else if (scan_q == (len_q - ONE)) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end else begin
                  scan_q <= scan_q + ONE;
               end
            end
            S_DONE: begin
               done_q  <= 1'b0;
               state_q <= coll_q ? S_DEAD : S_IDLE;
            end
            S_DEAD: begin
               state_q <= S_DEAD;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign snake_out = body_q;
   assign index     = index_q;
   assign head_x    = seg_x(body_q[SEG_W-1:0]);
   assign head_y    = seg_y(body_q[SEG_W-1:0]);
   assign busy      = busy_q;
   assign done      = done_q;
   assign collision = coll_q;

endmodule

// File: tb/tb_snake_body_updater.sv
// Self-checking bench for snake_body_updater against a queue-based snake model.
module tb_snake_body_updater;

   localparam int BODY_W   = 1800;
   localparam int MAX_SEGS = 225;

   logic              clk = 1'b0;
   logic              reset, tick, grow;
   logic [1:0]        dir;
   logic [BODY_W-1:0] snake_out;
   logic [10:0]       index;
   logic [3:0]        head_x, head_y;
   logic              busy, done, collision;

   int tests, fails;

   // Model: body as a queue of {y,x} bytes, head first.
   logic [7:0] mq[$];
   int         m_dir;
   bit         m_coll;

   snake_body_updater dut (
      .clk       (clk),
      .reset     (reset),
      .tick      (tick),
      .dir       (dir),
      .grow      (grow),
      .snake_out (snake_out),
      .index     (index),
      .head_x    (head_x),
      .head_y    (head_y),
      .busy      (busy),
      .done      (done),
      .collision (collision)
   );

   always #5 clk = ~clk;

   function automatic logic [BODY_W-1:0] init_image();
      logic [BODY_W-1:0] b;
      b = '0;
      b[23:0] = 24'h868788;
      return b;
   endfunction

   function automatic logic [BODY_W-1:0] model_body();
      logic [BODY_W-1:0] b;
      b = '0;
      foreach (mq[i]) b[i*8 +: 8] = mq[i];
      return b;
   endfunction

   function automatic int first_diff(input logic [BODY_W-1:0] a, input logic [BODY_W-1:0] b);
      for (int k = 0; k < MAX_SEGS; k++)
         if (a[k*8 +: 8] !== b[k*8 +: 8]) return k;
      return -1;
   endfunction

   task automatic model_reset();
      mq.delete();
      mq.push_back(8'h88);
      mq.push_back(8'h87);
      mq.push_back(8'h86);
      m_dir  = 1;
      m_coll = 0;
   endtask

   task automatic model_move(input logic [1:0] d, input logic g, output int scans);
      int         nd;
      logic [3:0] x, y;
      logic [7:0] h;
      nd = int'(d);
      if (nd == (m_dir + 2) % 4) nd = m_dir;
      m_dir = nd;
      h = mq[0];
      x = h[3:0];
      y = h[7:4];
      case (nd)
         0:       y = y - 4'd1;
         1:       x = x + 4'd1;
         2:       y = y + 4'd1;
         default: x = x - 4'd1;
      endcase
      mq.push_front({y, x});
      if (!(g && mq.size() <= MAX_SEGS)) void'(mq.pop_back());
      scans = mq.size() - 1;
      for (int i = 1; i < mq.size(); i++) begin
         if (mq[i] == mq[0]) begin
            m_coll = 1;
            scans  = i;
            break;
         end
      end
   endtask

   task automatic apply_reset();
      tick  = 1'b0;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      model_reset();
   endtask

   // One accepted move: checks busy window length, done pulse, body, index and collision.
   task automatic run_move(input logic [1:0] d, input logic g);
      int                scans, k;
      logic [BODY_W-1:0] exp_body;
      logic [10:0]       exp_idx;
      tick = 1'b1; dir = d; grow = g;
      @(posedge clk); #1;
      model_move(d, g, scans);
      exp_body = model_body();
      exp_idx  = 11'((mq.size() - 1) * 8);
      for (int c = 0; c <= scans; c++) begin
         tests++;
         if (busy !== 1'b1 || done !== 1'b0) begin
            fails++;
            $display("FAIL move_busy cycle %0d: busy=%b done=%b, want busy=1 done=0", c, busy, done);
         end
         tick = 1'($urandom); dir = 2'($urandom); grow = 1'($urandom);
         @(posedge clk); #1;
      end
      tick = 1'b0;
      tests++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         fails++;
         $display("FAIL move_done: busy=%b done=%b, want busy=0 done=1", busy, done);
      end
      tests++;
      k = first_diff(snake_out, exp_body);
      if (k >= 0) begin
         fails++;
         $display("FAIL move_body seg %0d: got %h want %h", k, snake_out[k*8 +: 8], exp_body[k*8 +: 8]);
      end
      tests++;
      if (index !== exp_idx) begin
         fails++;
         $display("FAIL move_index: got %0d want %0d", index, exp_idx);
      end
      tests++;
      if (collision !== m_coll) begin
         fails++;
         $display("FAIL move_collision: got %b want %b", collision, m_coll);
      end
      tests++;
      if (head_x !== exp_body[3:0] || head_y !== exp_body[7:4]) begin
         fails++;
         $display("FAIL move_head: got (%0d,%0d) want (%0d,%0d)", head_x, head_y, exp_body[3:0], exp_body[7:4]);
      end
      @(posedge clk); #1;
      tests++;
      if (done !== 1'b0) begin
         fails++;
         $display("FAIL done_pulse_width: done=%b want 0", done);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; tick = 1'b0; dir = 2'b00; grow = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
      @(posedge clk); #1;
      tests++;
      if (snake_out !== init_image()) begin
         fails++;
         $display("FAIL reset_body: got low %h want low %h", snake_out[31:0], 32'h00868788);
      end
      tests++;
      if (index !== 11'd16 || head_x !== 4'd8 || head_y !== 4'd8) begin
         fails++;
         $display("FAIL reset_index_head: index=%0d head=(%0d,%0d) want 16 (8,8)", index, head_x, head_y);
      end
      tests++;
      if (busy !== 1'b0 || done !== 1'b0 || collision !== 1'b0) begin
         fails++;
         $display("FAIL reset_flags: busy=%b done=%b coll=%b want 000", busy, done, collision);
      end
   endtask

   task automatic test_basic_move();
      apply_reset();
      run_move(2'b01, 1'b0);
      tests++;
      if (snake_out[31:0] !== 32'h00878889 || index !== 11'd16) begin
         fails++;
         $display("FAIL basic_move: low=%h index=%0d want 00878889 16", snake_out[31:0], index);
      end
   endtask

   task automatic test_wrap();
      apply_reset();
      repeat (7) run_move(2'b01, 1'b0);
      tests++;
      if (head_x !== 4'd15) begin
         fails++;
         $display("FAIL wrap_pre_x: head_x=%0d want 15", head_x);
      end
      run_move(2'b01, 1'b0);
      tests++;
      if (head_x !== 4'd0 || head_y !== 4'd8) begin
         fails++;
         $display("FAIL wrap_x: head=(%0d,%0d) want (0,8)", head_x, head_y);
      end
      repeat (8) run_move(2'b00, 1'b0);
      run_move(2'b00, 1'b0);
      tests++;
      if (head_x !== 4'd0 || head_y !== 4'd15) begin
         fails++;
         $display("FAIL wrap_y: head=(%0d,%0d) want (0,15)", head_x, head_y);
      end
   endtask

   task automatic test_reversal();
      apply_reset();
      run_move(2'b11, 1'b0);
      tests++;
      if (head_x !== 4'd9 || head_y !== 4'd8) begin
         fails++;
         $display("FAIL reversal: head=(%0d,%0d) want (9,8)", head_x, head_y);
      end
   endtask

   task automatic test_tail_chase();
      apply_reset();
      run_move(2'b01, 1'b1);
      run_move(2'b10, 1'b0);
      run_move(2'b11, 1'b0);
      run_move(2'b00, 1'b0);
      tests++;
      if (collision !== 1'b0 || head_x !== 4'd8 || head_y !== 4'd8) begin
         fails++;
         $display("FAIL tail_chase: coll=%b head=(%0d,%0d) want 0 (8,8)", collision, head_x, head_y);
      end
   endtask

   task automatic test_grow_and_collide();
      logic [BODY_W-1:0] frozen;
      apply_reset();
      run_move(2'b01, 1'b1);
      run_move(2'b01, 1'b1);
      tests++;
      if (index !== 11'd32 || head_x !== 4'd10 || head_y !== 4'd8) begin
         fails++;
         $display("FAIL grow: index=%0d head=(%0d,%0d) want 32 (10,8)", index, head_x, head_y);
      end
      run_move(2'b10, 1'b0);
      run_move(2'b11, 1'b0);
      run_move(2'b00, 1'b0);
      tests++;
      if (collision !== 1'b1 || snake_out[39:32] !== 8'h89) begin
         fails++;
         $display("FAIL collide: coll=%b seg4=%h want 1 89", collision, snake_out[39:32]);
      end
      frozen = model_body();
      for (int c = 0; c < 6; c++) begin
         tick = 1'b1; dir = 2'($urandom); grow = 1'($urandom);
         @(posedge clk); #1;
         tests++;
         if (busy !== 1'b0 || done !== 1'b0 || snake_out !== frozen || collision !== 1'b1) begin
            fails++;
            $display("FAIL dead_ignore cycle %0d: busy=%b done=%b coll=%b", c, busy, done, collision);
         end
      end
      tick = 1'b0;
   endtask

   task automatic test_reset_mid_scan();
      apply_reset();
      repeat (3) run_move(2'b01, 1'b1);
      tick = 1'b1; dir = 2'b01; grow = 1'b0;
      @(posedge clk); #1;
      tick = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      tests++;
      if (snake_out !== init_image() || index !== 11'd16) begin
         fails++;
         $display("FAIL midscan_reset_body: low=%h index=%0d want 00868788 16", snake_out[31:0], index);
      end
      tests++;
      if (busy !== 1'b0 || done !== 1'b0 || collision !== 1'b0) begin
         fails++;
         $display("FAIL midscan_reset_flags: busy=%b done=%b coll=%b want 000", busy, done, collision);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      model_reset();
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         tests++;
         if (done !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL midscan_no_done cycle %0d: done=%b busy=%b", c, done, busy);
         end
      end
   endtask

   task automatic test_random();
      apply_reset();
      for (int n = 0; n < 80; n++) begin
         run_move(2'($urandom), ($urandom_range(0, 3) == 0));
         if (m_coll) apply_reset();
      end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      reset = 1'b1; tick = 1'b0; dir = 2'b00; grow = 1'b0;
      test_reset();
      test_basic_move();
      test_wrap();
      test_reversal();
      test_tail_chase();
      test_grow_and_collide();
      test_reset_mid_scan();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
